// File: rtl/aes_inv_sbox.sv
// AES inverse S-box: GF(2^8) inverse of the inverse-affine-transformed input.
// Latency: purely combinational, zero cycles.
// Backpressure: none, it is a pure function of its input.
//
// Ports:
//   data_i  8-bit substituted byte
//   data_o  8-bit original byte, InvSubBytes(data_i)
module aes_inv_sbox (
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    // Shift-and-add multiply modulo x^8+x^4+x^3+x+1, built only from XOR/AND.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] aff;
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, x254;

    // Undo the forward affine step first; the inverse then follows as a^254.
    assign aff  = {data_i[6:0], data_i[7]} ^ {data_i[4:0], data_i[7:5]}
                ^ {data_i[1:0], data_i[7:2]} ^ 8'h05;

    // Addition chain for a^254; zero maps to zero as required.
    assign x2   = gf_mul(aff, aff);
    assign x3   = gf_mul(x2, aff);
    assign x6   = gf_mul(x3, x3);
    assign x12  = gf_mul(x6, x6);
    assign x15  = gf_mul(x12, x3);
    assign x30  = gf_mul(x15, x15);
    assign x60  = gf_mul(x30, x30);
    assign x120 = gf_mul(x60, x60);
    assign x240 = gf_mul(x120, x120);
    assign x252 = gf_mul(x240, x12);
    assign x254 = gf_mul(x252, x2);

    assign data_o = x254;

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryption, one round per clock from a precomputed expanded key.
// Latency: out_valid pulses 10 clocks after the accepting edge; one block per 11 clocks at best.
// Backpressure: start is only honoured while busy=0; requests while busy are dropped, not queued.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   start         request, sampled only while idle
//   cipher_in     128-bit cipher block, byte k at [8k+7:8k] = row k%4, column k/4
//   expanded_key  11 round keys, round key r at [128r+127:128r]
//   busy          high from the accepting edge until the final-round edge
//   out_valid     one-cycle completion pulse
//   plain_out     recovered plain text, held until the next completion
// Optional build macro AES_DEC_KEY_CAPTURE_EN: registers expanded_key at accept so the
// caller may change it while busy. Without it the key must stay stable for the whole block.
module aes_decrypt_iter #(
    parameter int NR = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [127:0]  cipher_in,
    input  logic [1407:0] expanded_key,
    output logic          busy,
    output logic          out_valid,
    output logic [127:0]  plain_out
);

    typedef enum logic {
        IDLE  = 1'b0,
        ROUND = 1'b1
    } fsm_e;

    fsm_e          fsm_q, fsm_d;
    logic [127:0]  state_q, state_d;
    logic [127:0]  plain_q, plain_d;
    logic [3:0]    ctr_q, ctr_d;
    logic          busy_q, busy_d;
    logic          vld_q, vld_d;

    logic          accept;
    logic [1407:0] round_keys;
    logic [127:0]  rk;
    logic [127:0]  shifted;
    logic [127:0]  subbed;
    logic [127:0]  add_rk;
    logic [127:0]  mixed;

    assign accept = (fsm_q == IDLE) && start;

`ifdef AES_DEC_KEY_CAPTURE_EN
    logic [1407:0] key_q;

    // The accept edge itself reads rk10 straight from the port; every later round uses this copy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_q <= '0;
        end else if (accept) begin
            key_q <= expanded_key;
        end
    end

    assign round_keys = key_q;
`else
    assign round_keys = expanded_key;
`endif

    // The counter doubles as the round-key index.
    assign rk = round_keys[{ctr_q, 7'd0} +: 128];

    // InvShiftRows: row r rotates right by r, so column c takes the byte from column c-r.
    always_comb begin
        shifted = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[8*(4*c+r) +: 8] = state_q[8*(4*((c+4-r)%4)+r) +: 8];
            end
        end
    end

    for (genvar k = 0; k < 16; k++) begin : g_sbox
        aes_inv_sbox u_inv_sbox (
            .data_i (shifted[8*k +: 8]),
            .data_o (subbed[8*k +: 8])
        );
    end

    assign add_rk = subbed ^ rk;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // InvMixColumns with the 09/0b/0d/0e products composed from chained xtime.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a   [4];
        logic [7:0] m09 [4];
        logic [7:0] m0b [4];
        logic [7:0] m0d [4];
        logic [7:0] m0e [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]   = col[8*i +: 8];
            x2     = xtime(a[i]);
            x4     = xtime(x2);
            x8     = xtime(x4);
            m09[i] = x8 ^ a[i];
            m0b[i] = x8 ^ x2 ^ a[i];
            m0d[i] = x8 ^ x4 ^ a[i];
            m0e[i] = x8 ^ x4 ^ x2;
        end
        return {m0b[0] ^ m0d[1] ^ m09[2] ^ m0e[3],
                m0d[0] ^ m09[1] ^ m0e[2] ^ m0b[3],
                m09[0] ^ m0e[1] ^ m0b[2] ^ m0d[3],
                m0e[0] ^ m0b[1] ^ m0d[2] ^ m09[3]};
    endfunction

    always_comb begin
        mixed = '0;
        for (int c = 0; c < 4; c++) begin
            mixed[32*c +: 32] = inv_mix_col(add_rk[32*c +: 32]);
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        ctr_d   = ctr_q;
        busy_d  = busy_q;
        vld_d   = 1'b0;
        plain_d = plain_q;
        case (fsm_q)
            IDLE: begin
                if (start) begin
                    state_d = cipher_in ^ expanded_key[128*NR +: 128];
                    ctr_d   = 4'(NR - 1);
                    busy_d  = 1'b1;
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                if (ctr_q == 4'd0) begin
                    // Final round has no InvMixColumns.
                    plain_d = add_rk;
                    vld_d   = 1'b1;
                    busy_d  = 1'b0;
                    fsm_d   = IDLE;
                end else begin
                    state_d = mixed;
                    ctr_d   = ctr_q - 4'd1;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= '0;
            ctr_q   <= '0;
            busy_q  <= 1'b0;
            vld_q   <= 1'b0;
            plain_q <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            busy_q  <= busy_d;
            vld_q   <= vld_d;
            plain_q <= plain_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = vld_q;
    assign plain_out = plain_q;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Directed bench for aes_decrypt_iter: FIPS-197 C.1, round trips against a forward-AES model,
// start collisions while busy, asynchronous reset mid-block, and streaming with start held high.
module tb_aes_decrypt_iter;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [127:0]  cipher_in;
    logic [1407:0] expanded_key;
    logic          busy;
    logic          out_valid;
    logic [127:0]  plain_out;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    aes_decrypt_iter dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cipher_in    (cipher_in),
        .expanded_key (expanded_key),
        .busy         (busy),
        .out_valid    (out_valid),
        .plain_out    (plain_out)
    );

    // ---------------- forward AES-128 reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b};
        return d[15-n -: 8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] b;
        // x^254 by repeated multiplication
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, x);
        b = (x == 8'h00) ? 8'h00 : r;
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [1407:0] key_expand(input logic [127:0] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1407:0] ek;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[7:0], t[31:8]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
                t[7:0] = t[7:0] ^ rc;
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        ek = '0;
        for (int i = 0; i < 44; i++) ek[32*i +: 32] = w[i];
        return ek;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1407:0] ek);
        logic [127:0] s;
        logic [127:0] n;
        logic [7:0]   a [4];
        s = pt ^ ek[127:0];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int k = 0; k < 16; k++) s[8*k +: 8] = sbox(s[8*k +: 8]);
            n = '0;
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    n[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
            s = n;
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) a[r] = s[8*(4*c+r) +: 8];
                    s[8*(4*c+0) +: 8] = gmul(a[0], 8'h02) ^ gmul(a[1], 8'h03) ^ a[2] ^ a[3];
                    s[8*(4*c+1) +: 8] = a[0] ^ gmul(a[1], 8'h02) ^ gmul(a[2], 8'h03) ^ a[3];
                    s[8*(4*c+2) +: 8] = a[0] ^ a[1] ^ gmul(a[2], 8'h02) ^ gmul(a[3], 8'h03);
                    s[8*(4*c+3) +: 8] = gmul(a[0], 8'h03) ^ a[1] ^ a[2] ^ gmul(a[3], 8'h02);
                end
            end
            s = s ^ ek[128*rnd +: 128];
        end
        return s;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One block: accept at E0, optional start collisions at E3/E10, optional key change at E2.
    task automatic run_block(input string tag, input logic [127:0] ct, input logic [1407:0] ek,
                             input logic [127:0] pt, input bit collide, input bit change_key);
        expanded_key = ek;
        cipher_in    = ct;
        start        = 1'b1;
        tick();
        start     = 1'b0;
        cipher_in = {$urandom, $urandom, $urandom, $urandom};
        chk({tag, " busy@E0"}, {127'd0, busy}, 128'd1);
        for (int e = 1; e <= 10; e++) begin
            start = collide && (e == 3 || e == 10);
            if (start) cipher_in = 128'h0;
            if (change_key && e == 2) expanded_key = {1408{1'b1}};
            tick();
            if (e < 10) begin
                chk({tag, " busy/vld mid"}, {126'd0, busy, out_valid}, 128'b10);
            end else begin
                chk({tag, " busy/vld E10"}, {126'd0, busy, out_valid}, 128'b01);
                chk({tag, " plain"}, plain_out, pt);
            end
        end
        start        = 1'b0;
        expanded_key = ek;
        tick();
        chk({tag, " busy/vld E11"}, {126'd0, busy, out_valid}, 128'b00);
        chk({tag, " plain held"}, plain_out, pt);
    endtask

    localparam logic [127:0] FIPS_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] FIPS_CT  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
    localparam logic [127:0] FIPS_PT  = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] RT_KEY   = 128'h100F0E0D0C0B0A090807060504030201;
    localparam logic [127:0] RT_PT0   = 128'h00FFFEFDFCFBFAF9F8F7F6F5F4F3F2F1;

    initial begin
        logic [1407:0] ek_fips;
        logic [1407:0] ek_rt;
        logic [127:0]  pts [4];
        logic [127:0]  cts [4];
        logic [127:0]  p;
        logic [7:0]    m;

        ek_fips = key_expand(FIPS_KEY);
        ek_rt   = key_expand(RT_KEY);

        rst          = 1'b1;
        start        = 1'b0;
        cipher_in    = '0;
        expanded_key = ek_fips;
        #2 rst = 1'b0;
        #1;
        chk("reset busy", {127'd0, busy}, 128'd0);
        chk("reset out_valid", {127'd0, out_valid}, 128'd0);
        chk("reset plain_out", plain_out, 128'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        tick();

        // FIPS-197 C.1
        run_block("fips", FIPS_CT, ek_fips, FIPS_PT, 1'b0, 1'b0);

        // Round trips through the forward model
        for (int i = 0; i < 15; i++) begin
            m = 8'(i * 17);
            p = RT_PT0 ^ {16{m}};
            run_block($sformatf("rt%0d", i), encrypt(p, ek_rt), ek_rt, p, 1'b0, 1'b0);
        end

        // Requests at E3 and E10 must be dropped
        run_block("collide", FIPS_CT, ek_fips, FIPS_PT, 1'b1, 1'b0);
        tick();
        chk("collide no restart", {126'd0, busy, out_valid}, 128'b00);

        // Asynchronous reset between E5 and E6
        expanded_key = ek_fips;
        cipher_in    = FIPS_CT;
        start        = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        #2 rst = 1'b0;
        #1;
        chk("midreset busy", {127'd0, busy}, 128'd0);
        chk("midreset out_valid", {127'd0, out_valid}, 128'd0);
        chk("midreset plain_out", plain_out, 128'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("postreset idle", {126'd0, busy, out_valid}, 128'b00);
        end
        run_block("after reset", FIPS_CT, ek_fips, FIPS_PT, 1'b0, 1'b0);

        // Streaming with start held high
        for (int i = 0; i < 4; i++) begin
            m      = 8'(8'h3c + i * 8'h51);
            pts[i] = {RT_PT0[119:0], RT_PT0[127:120]} ^ {16{m}};
            cts[i] = encrypt(pts[i], ek_rt);
        end
        expanded_key = ek_rt;
        cipher_in    = cts[0];
        start        = 1'b1;
        tick();
        cipher_in = cts[1];
        for (int t = 1; t <= 43; t++) begin
            tick();
            if (t % 11 == 10) begin
                chk($sformatf("stream vld t%0d", t), {127'd0, out_valid}, 128'd1);
                chk($sformatf("stream plain t%0d", t), plain_out, pts[t/11]);
            end else begin
                chk($sformatf("stream idle t%0d", t), {127'd0, out_valid}, 128'd0);
                if (t > 10) chk($sformatf("stream hold t%0d", t), plain_out, pts[(t-10)/11]);
            end
            if (t == 11) cipher_in = cts[2];
            if (t == 22) cipher_in = cts[3];
            if (t == 33) start = 1'b0;
        end
        tick();
        chk("stream end", {126'd0, busy, out_valid}, 128'b00);

`ifdef AES_DEC_KEY_CAPTURE_EN
        run_block("keycap", FIPS_CT, ek_fips, FIPS_PT, 1'b0, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
